// File: rtl/fetch_unit_if.sv
// Shared RV32I branch encoding plus the fetch unit's bus bundle: imem request/response,
// decode handshake and execute-stage redirect inputs.
package rv32i;
    typedef enum logic [1:0] {
        BRANCH_NONE     = 2'd0,
        BRANCH_RELATIVE = 2'd1,
        BRANCH_ABSOLUTE = 2'd2
    } branch_type_e;
endpackage

interface fetch_unit_if;
    import rv32i::*;

    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [31:0]  imem_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic         inst_valid;
    logic         inst_ready;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         exec_valid;
    branch_type_e branch_type;
    logic [31:0]  exec_pc;
    logic [31:0]  exec_imm;
    logic [31:0]  alu_result;
    logic         fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               exec_valid, branch_type, exec_pc, exec_imm, alu_result
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               exec_valid, branch_type, exec_pc, exec_imm, alu_result
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer with one outstanding imem request and a held word for decode.
// RV32I_FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_fault and halt.
module fetch_unit
    import rv32i::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
        S_HALT,
`endif
        S_HOLD
    } state_e;

    state_e      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic        drop_reg, drop_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_pc_reg, inst_pc_next;
    logic        req_valid, inst_valid;
    logic        redirect;
    logic [31:0] target_raw, target;

    assign redirect   = bus.exec_valid && (bus.branch_type != BRANCH_NONE);
    assign target_raw = (bus.branch_type == BRANCH_RELATIVE) ? (bus.exec_pc + bus.exec_imm)
                                                             : bus.alu_result;

`ifdef RV32I_FETCH_ALIGN_CHECK_EN
    logic fault_reg, fault_next;
    logic misaligned;

    assign target     = target_raw;
    assign misaligned = redirect && (target_raw[1:0] != 2'b00);
    assign bus.fetch_fault = fault_reg;
`else
    // Without the check, the low bits are simply discarded so fetch stays word aligned.
    assign target = target_raw & 32'hFFFF_FFFC;
    assign bus.fetch_fault = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        drop_next     = drop_reg;
        inst_next     = inst_reg;
        inst_pc_next  = inst_pc_reg;
        req_valid     = 1'b0;
        inst_valid    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
                if (redirect) begin
                    fetch_pc_next = target;
                    req_addr_next = target;
                end else begin
                    req_addr_next = fetch_pc_reg;
                end
            end
            S_REQ: begin
                req_valid = 1'b1;
                // The address must stay put until accepted; a redirect only poisons the response.
                if (redirect) begin
                    fetch_pc_next = target;
                    drop_next     = 1'b1;
                end
                if (bus.imem_req_ready) begin
                    state_next = S_WAIT;
                    if (!drop_reg && !redirect) fetch_pc_next = req_addr_reg + 32'd4;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_next = target;
                    drop_next     = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    if (drop_reg || redirect) begin
                        drop_next     = 1'b0;
                        state_next    = S_REQ;
                        req_addr_next = redirect ? target : fetch_pc_reg;
                    end else begin
                        inst_next    = bus.imem_rsp_data;
                        inst_pc_next = req_addr_reg;
                        state_next   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Masking valid during a redirect keeps decode from taking the stale word.
                inst_valid = !redirect;
                if (redirect) begin
                    state_next    = S_REQ;
                    fetch_pc_next = target;
                    req_addr_next = target;
                end else if (bus.inst_ready) begin
                    state_next    = S_REQ;
                    req_addr_next = fetch_pc_reg;
                end
            end
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
            S_HALT: begin
            end
`endif
            default: state_next = S_IDLE;
        endcase
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
        fault_next = fault_reg;
        if (misaligned && (state_reg != S_HALT)) begin
            state_next = S_HALT;
            fault_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
            drop_reg     <= 1'b0;
            inst_reg     <= 32'd0;
            inst_pc_reg  <= 32'd0;
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
            fault_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_addr_reg <= req_addr_next;
            drop_reg     <= drop_next;
            inst_reg     <= inst_next;
            inst_pc_reg  <= inst_pc_next;
`ifdef RV32I_FETCH_ALIGN_CHECK_EN
            fault_reg    <= fault_next;
`endif
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = req_addr_reg;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst           = inst_reg;
    assign bus.inst_pc        = inst_pc_reg;

endmodule
